// File: rtl/rvh_l1d_pkg.sv
// Shared L1D definitions: index widths and the PLRU hit-update payload.
package rvh_l1d_pkg;

    localparam int unsigned L1D_ENTRY_NUM = 32;
    localparam int unsigned L1D_WAY_NUM   = 4;
    localparam int unsigned SET_W         = $clog2(L1D_ENTRY_NUM);
    localparam int unsigned WAY_W         = $clog2(L1D_WAY_NUM);

    typedef struct packed {
        logic [SET_W-1:0] set;
        logic [WAY_W-1:0] way;
    } plru_hit_req_t;

endpackage

// File: rtl/rvh_l1d_plru_hit_q.sv
// Multi-enqueue, single-dequeue circular FIFO of PLRU hit updates.
module rvh_l1d_plru_hit_q
    import rvh_l1d_pkg::*;
#(
    parameter int unsigned PORT_NUM = 2,
    parameter int unsigned DEPTH    = 4,
    localparam int unsigned PTR_W   = $clog2(DEPTH),
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush_i,
    input  logic [PORT_NUM-1:0]          enq_vld_i,
    input  plru_hit_req_t [PORT_NUM-1:0] enq_req_i,
    input  logic                         deq_i,
    output plru_hit_req_t                head_c,
    output logic [CNT_W-1:0]             cnt_o,
    output logic [CNT_W-1:0]             free_c,
    output logic [PORT_NUM-1:0]          acc_mask_c
);

    plru_hit_req_t      mem_q [DEPTH];
    plru_hit_req_t      mem_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   n_acc;

    // Slots available this cycle; lower port indices claim them first.
    always_comb begin
        free_c     = CNT_W'(DEPTH) - cnt_q + CNT_W'(deq_i);
        acc_mask_c = '0;
        n_acc      = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            if (enq_vld_i[i] && (n_acc < free_c)) begin
                acc_mask_c[i] = 1'b1;
                n_acc         = n_acc + CNT_W'(1);
            end
        end
    end

    // Next pointers, count and storage; flush empties the queue at the edge.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + n_acc - CNT_W'(deq_i);
        for (int i = 0; i < PORT_NUM; i++) begin
            if (acc_mask_c[i]) begin
                mem_d[wr_ptr_d] = enq_req_i[i];
                wr_ptr_d        = wr_ptr_d + PTR_W'(1);
            end
        end
        if (deq_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (flush_i) begin
            mem_d    = mem_q;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_c = mem_q[rd_ptr_q];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/rvh_l1d_plru_arb.sv
// Serialises PLRU hit updates and refill victim reads onto a shared PLRU.
module rvh_l1d_plru_arb
    import rvh_l1d_pkg::*;
#(
    parameter int unsigned ENTRY_NUM    = L1D_ENTRY_NUM,
    parameter int unsigned WAY_NUM      = L1D_WAY_NUM,
    parameter int unsigned HIT_PORT_NUM = 2,
    parameter int unsigned HIT_Q_DEPTH  = 4,
    localparam int unsigned SET_IDX_W   = $clog2(ENTRY_NUM),
    localparam int unsigned WAY_IDX_W   = $clog2(WAY_NUM)
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [HIT_PORT_NUM-1:0]           hit_vld_i,
    input  logic [HIT_PORT_NUM*SET_IDX_W-1:0] hit_set_i,
    input  logic [HIT_PORT_NUM*WAY_IDX_W-1:0] hit_way_i,
    input  logic                              flush_i,
    input  logic                              refill_req_vld_i,
    input  logic [SET_IDX_W-1:0]              refill_req_set_i,
    output logic                              refill_req_rdy_o,
    output logic                              refill_resp_vld_o,
    output logic [SET_IDX_W-1:0]              refill_resp_set_o,
    output logic [WAY_IDX_W-1:0]              refill_resp_way_o,
    output logic                              plru_upd_en_hit_o,
    output logic [SET_IDX_W-1:0]              plru_upd_set_idx_hit_o,
    output logic [WAY_IDX_W-1:0]              plru_upd_way_idx_hit_o,
    output logic                              plru_rd_en_refill_o,
    output logic [SET_IDX_W-1:0]              plru_rd_idx_refill_o,
    input  logic [WAY_IDX_W-1:0]              plru_rd_dat_refill_i,
    output logic [7:0]                        hit_drop_cnt_o
);

    localparam int unsigned CNT_W = $clog2(HIT_Q_DEPTH) + 1;

    plru_hit_req_t [HIT_PORT_NUM-1:0] hit_req;
    plru_hit_req_t                    q_head;
    logic [CNT_W-1:0]                 q_cnt;
    logic [CNT_W-1:0]                 q_free;
    logic [HIT_PORT_NUM-1:0]          q_acc;
    logic                             q_full;
    logic                             refill_fire;
    logic                             drain;

    logic                 resp_vld_q, resp_vld_d;
    logic [SET_IDX_W-1:0] resp_set_q, resp_set_d;
    logic [WAY_IDX_W-1:0] resp_way_q, resp_way_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;
    logic [7:0]           n_drop;
    logic [8:0]           drop_sum;

    // Unpack the per-port hit buses into queue entries.
    always_comb begin
        hit_req = '0;
        for (int i = 0; i < HIT_PORT_NUM; i++) begin
            hit_req[i].set = SET_W'(hit_set_i[i*SET_IDX_W +: SET_IDX_W]);
            hit_req[i].way = WAY_W'(hit_way_i[i*WAY_IDX_W +: WAY_IDX_W]);
        end
    end

    rvh_l1d_plru_hit_q #(
        .PORT_NUM (HIT_PORT_NUM),
        .DEPTH    (HIT_Q_DEPTH)
    ) u_hit_q (
        .clk        (clk),
        .rstn       (rstn),
        .flush_i    (flush_i),
        .enq_vld_i  (hit_vld_i),
        .enq_req_i  (hit_req),
        .deq_i      (drain),
        .head_c     (q_head),
        .cnt_o      (q_cnt),
        .free_c     (q_free),
        .acc_mask_c (q_acc)
    );

    // Refill wins unless the queue is full; a full queue always drains.
    always_comb begin
        q_full      = (q_cnt == CNT_W'(HIT_Q_DEPTH));
        refill_fire = refill_req_vld_i & ~q_full & rstn;
        drain       = (q_cnt != '0) & ~refill_fire;
    end

    // PLRU-facing port drive; idle ports present zero indices.
    always_comb begin
        refill_req_rdy_o       = ~q_full & rstn;
        plru_rd_en_refill_o    = refill_fire;
        plru_rd_idx_refill_o   = refill_fire ? refill_req_set_i : '0;
        plru_upd_en_hit_o      = drain;
        plru_upd_set_idx_hit_o = drain ? SET_IDX_W'(q_head.set) : '0;
        plru_upd_way_idx_hit_o = drain ? WAY_IDX_W'(q_head.way) : '0;
    end

    // Response capture and saturating drop count; flushed enqueues are not drops.
    always_comb begin
        resp_vld_d = refill_fire;
        resp_set_d = refill_fire ? refill_req_set_i     : resp_set_q;
        resp_way_d = refill_fire ? plru_rd_dat_refill_i : resp_way_q;
        n_drop     = '0;
        for (int i = 0; i < HIT_PORT_NUM; i++) begin
            if (hit_vld_i[i] && !q_acc[i] && !flush_i) begin
                n_drop = n_drop + 8'd1;
            end
        end
        drop_sum   = 9'(drop_cnt_q) + 9'(n_drop);
        drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // Response and drop counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_vld_q <= 1'b0;
            resp_set_q <= '0;
            resp_way_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            resp_vld_q <= resp_vld_d;
            resp_set_q <= resp_set_d;
            resp_way_q <= resp_way_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign refill_resp_vld_o = resp_vld_q;
    assign refill_resp_set_o = resp_set_q;
    assign refill_resp_way_o = resp_way_q;
    assign hit_drop_cnt_o    = drop_cnt_q;

    // q_free is consumed inside the queue; observed here only for completeness.
    logic unused_free;
    assign unused_free = ^q_free;

endmodule

// File: tb/tb_rvh_l1d_plru_arb.sv
// Directed-vector bench for rvh_l1d_plru_arb.
module tb_rvh_l1d_plru_arb;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] hit_vld;
    logic [9:0] hit_set;
    logic [3:0] hit_way;
    logic       flush;
    logic       rf_vld;
    logic [4:0] rf_set;
    logic       rf_rdy;
    logic       resp_vld;
    logic [4:0] resp_set;
    logic [1:0] resp_way;
    logic       upd_en;
    logic [4:0] upd_set;
    logic [1:0] upd_way;
    logic       rd_en;
    logic [4:0] rd_idx;
    logic [1:0] rd_dat;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rvh_l1d_plru_arb dut (
        .clk                    (clk),
        .rstn                   (rstn),
        .hit_vld_i              (hit_vld),
        .hit_set_i              (hit_set),
        .hit_way_i              (hit_way),
        .flush_i                (flush),
        .refill_req_vld_i       (rf_vld),
        .refill_req_set_i       (rf_set),
        .refill_req_rdy_o       (rf_rdy),
        .refill_resp_vld_o      (resp_vld),
        .refill_resp_set_o      (resp_set),
        .refill_resp_way_o      (resp_way),
        .plru_upd_en_hit_o      (upd_en),
        .plru_upd_set_idx_hit_o (upd_set),
        .plru_upd_way_idx_hit_o (upd_way),
        .plru_rd_en_refill_o    (rd_en),
        .plru_rd_idx_refill_o   (rd_idx),
        .plru_rd_dat_refill_i   (rd_dat),
        .hit_drop_cnt_o         (drop_cnt)
    );

    typedef struct {
        int hv; int s0; int w0; int s1; int w1; int fl; int rv; int rs; int rd;
        int e_rdy; int e_ren; int e_ridx; int e_uen; int e_us; int e_uw;
        int e_pv; int e_ps; int e_pw; int e_drop;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int hv, input int s0, input int w0, input int s1, input int w1,
                         input int fl, input int rv, input int rs, input int rd);
        hit_vld = 2'(hv);
        hit_set = {5'(s1), 5'(s0)};
        hit_way = {2'(w1), 2'(w0)};
        flush   = 1'(fl);
        rf_vld  = 1'(rv);
        rf_set  = 5'(rs);
        rd_dat  = 2'(rd);
    endtask

    initial begin
        //          hv s0 w0 s1 w1 fl rv rs rd | rdy ren ridx uen us uw pv ps pw drop
        vecs[0]  = '{1, 5, 2, 0, 0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0,  1, 5, 2, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{1, 7, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 1, 9, 3,  1, 1, 9,  0, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0,  1, 7, 1, 1, 9, 3, 0};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 9, 3, 0};
        vecs[7]  = '{3, 1, 0, 2, 1, 0, 1, 4, 0,  1, 1, 4,  0, 0, 0, 0, 9, 3, 0};
        vecs[8]  = '{1, 3, 2, 0, 0, 0, 1, 6, 1,  1, 1, 6,  0, 0, 0, 1, 4, 0, 0};
        vecs[9]  = '{3,10, 3,11, 0, 0, 1, 8, 2,  1, 1, 8,  0, 0, 0, 1, 6, 1, 0};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 1,12, 3,  0, 0, 0,  1, 1, 0, 1, 8, 2, 1};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 1,12, 3,  1, 1,12,  0, 0, 0, 0, 8, 2, 1};
        vecs[12] = '{1,20, 1, 0, 0, 0, 1,13, 1,  1, 1,13,  0, 0, 0, 1,12, 3, 1};
        vecs[13] = '{3,21, 2,22, 3, 1, 0, 0, 0,  0, 0, 0,  1, 2, 1, 1,13, 1, 1};
        vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0,13, 1, 1};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0,13, 1, 1};

        // Reset, with a refill request held to show enables stay low.
        rstn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1, 3, 1);
        #1;
        check("rst_rd_en",    int'(rd_en),    0);
        check("rst_upd_en",   int'(upd_en),   0);
        check("rst_resp_vld", int'(resp_vld), 0);
        check("rst_resp_set", int'(resp_set), 0);
        check("rst_resp_way", int'(resp_way), 0);
        check("rst_drop",     int'(drop_cnt), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rstn = 1'b1;

        // Table-driven cycles: drive on negedge, compare 1 ns later.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].hv, vecs[i].s0, vecs[i].w0, vecs[i].s1, vecs[i].w1,
                  vecs[i].fl, vecs[i].rv, vecs[i].rs, vecs[i].rd);
            #1;
            check($sformatf("v%0d_rdy", i),      int'(rf_rdy),   vecs[i].e_rdy);
            check($sformatf("v%0d_rd_en", i),    int'(rd_en),    vecs[i].e_ren);
            check($sformatf("v%0d_rd_idx", i),   int'(rd_idx),   vecs[i].e_ridx);
            check($sformatf("v%0d_upd_en", i),   int'(upd_en),   vecs[i].e_uen);
            check($sformatf("v%0d_upd_set", i),  int'(upd_set),  vecs[i].e_us);
            check($sformatf("v%0d_upd_way", i),  int'(upd_way),  vecs[i].e_uw);
            check($sformatf("v%0d_resp_vld", i), int'(resp_vld), vecs[i].e_pv);
            check($sformatf("v%0d_resp_set", i), int'(resp_set), vecs[i].e_ps);
            check($sformatf("v%0d_resp_way", i), int'(resp_way), vecs[i].e_pw);
            check($sformatf("v%0d_drop", i),     int'(drop_cnt), vecs[i].e_drop);
            check($sformatf("v%0d_excl", i),     int'(upd_en & rd_en), 0);
        end

        // Overflow: both ports every cycle, no refill. Queue reaches 0,2,3,4 then
        // drops one per cycle; drop count starts at 1 from the table section.
        @(negedge clk);
        drive(3, 4, 1, 5, 2, 0, 0, 0, 0);
        repeat (10) @(negedge clk);
        #1;
        check("ovf_drop_10", int'(drop_cnt), 8);
        check("ovf_rdy_full", int'(rf_rdy), 0);
        repeat (300) @(negedge clk);
        #1;
        check("ovf_drop_sat", int'(drop_cnt), 255);

        // Flush a full queue: same-cycle drain still fires, then nothing more.
        @(negedge clk);
        drive(1, 6, 3, 0, 0, 1, 0, 0, 0);
        #1;
        check("fl_upd_en", int'(upd_en), 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("fl_upd_en_after", int'(upd_en), 0);
        check("fl_rdy_after",    int'(rf_rdy), 1);
        check("fl_drop",         int'(drop_cnt), 255);
        @(negedge clk);
        #1;
        check("fl_upd_en_idle", int'(upd_en), 0);

        // Async reset while a refill response is pending.
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1, 17, 2);
        #1;
        check("ar_rd_en",  int'(rd_en),  1);
        check("ar_rd_idx", int'(rd_idx), 17);
        @(negedge clk);
        #1;
        check("ar_resp_vld", int'(resp_vld), 1);
        check("ar_resp_set", int'(resp_set), 17);
        check("ar_resp_way", int'(resp_way), 2);
        rstn = 1'b0;
        #1;
        check("ar_rst_vld",   int'(resp_vld), 0);
        check("ar_rst_set",   int'(resp_set), 0);
        check("ar_rst_way",   int'(resp_way), 0);
        check("ar_rst_drop",  int'(drop_cnt), 0);
        check("ar_rst_rd_en", int'(rd_en),    0);
        check("ar_rst_upd",   int'(upd_en),   0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("ar_post_vld%0d", k), int'(resp_vld), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rvh_l1d_plru_arb.md
# rvh_l1d_plru_arb

Scheduler in front of `rvh_l1d_plru`. It serialises access to the PLRU's single hit-update port and single refill-read port. The PLRU's next-state mux is shared between those ports, so they must never fire in the same cycle. The block buffers hit updates from several L1D pipes in a small queue, grants refill victim lookups with a valid/ready handshake, and returns the registered victim way one cycle later. It sits between the L1D load/store pipes and miss handler on one side and the PLRU instance on the other.

## Interface
- `ENTRY_NUM`, 32: sets; `SET_W = $clog2(ENTRY_NUM)`
- `WAY_NUM`, 4: ways; `WAY_W = $clog2(WAY_NUM)`
- `HIT_PORT_NUM`, 2: hit-update requesters
- `HIT_Q_DEPTH`, 4: hit queue entries, power of two, at least 2

Ports:
- `clk` in 1: clock
- `rstn` in 1: asynchronous, active-low reset
- `hit_vld_i` in HIT_PORT_NUM: per-port hit update valid; no ready
- `hit_set_i` in HIT_PORT_NUM*SET_W: packed set index per port
- `hit_way_i` in HIT_PORT_NUM*WAY_W: packed way index per port
- `flush_i` in 1: discard queued hit updates
- `refill_req_vld_i` in 1: victim lookup request
- `refill_req_set_i` in SET_W: set for the lookup
- `refill_req_rdy_o` out 1: lookup accepted this cycle
- `refill_resp_vld_o` out 1: one-cycle pulse, victim valid
- `refill_resp_set_o` out SET_W: set of the response
- `refill_resp_way_o` out WAY_W: victim way
- `plru_upd_en_hit_o` out 1: to PLRU `upd_en_hit`
- `plru_upd_set_idx_hit_o` out SET_W
- `plru_upd_way_idx_hit_o` out WAY_W
- `plru_rd_en_refill_o` out 1: to PLRU `rd_en_refill`
- `plru_rd_idx_refill_o` out SET_W
- `plru_rd_dat_refill_i` in WAY_W: combinational victim from PLRU
- `hit_drop_cnt_o` out 8: saturating count of dropped hit updates

## Operation
- **Hit queue.** Circular FIFO with `{set, way}` entries, a read pointer, a write pointer and a count.
  - Enqueue order is by ascending port index; port 0 is the oldest.
  - Slots available this cycle: `free = HIT_Q_DEPTH - count + deq`, where `deq` is the same-cycle drain.
  - Valid ports beyond `free` are dropped. Each dropped port increments `hit_drop_cnt_o` by one, saturating at 255.
- **Per-cycle arbitration.** At most one PLRU port fires per cycle.
  - Let `q_full = (count == HIT_Q_DEPTH)`, sampled at the start of the cycle.
  - Refill fire: `refill_req_vld_i & ~q_full`. `refill_req_rdy_o = ~q_full` and does not depend on `vld`.
  - Hit drain fires when `count != 0` and refill does not fire. This guarantees queue progress whenever the queue is full.
- **Refill fire.**
  - `plru_rd_en_refill_o = 1` and `plru_rd_idx_refill_o = refill_req_set_i`, both combinational.
  - `plru_rd_dat_refill_i` and the set are registered.
  - Next cycle: `refill_resp_vld_o = 1` with the registered set and way.
- **Hit drain.** `plru_upd_en_hit_o = 1`, with set and way taken from the queue head, combinationally. The read pointer advances.
- **Inactive PLRU outputs.** When a PLRU port is not firing, its index and way outputs are driven to 0.
- **Ordering.**
  - No bypass: a hit enqueued in cycle N drains in cycle N+1 at the earliest.
  - A refill to a set with older queued hits proceeds anyway; PLRU state is a hint only.
- **`flush_i`.**
  - Resets pointers and count at the clock edge.
  - Same-cycle enqueues are discarded and are not counted as drops.
  - A same-cycle drain still fires.
  - A refill or its response is unaffected.

## Timing
- **Reset values** (async on `rstn` low): queue empty, pointers 0, `refill_resp_vld_o = 0`, `refill_resp_set_o = 0`, `refill_resp_way_o = 0`, `hit_drop_cnt_o = 0`. All PLRU enables are 0 while in reset.
- **Refill latency:** request accepted in cycle N, response in cycle N+1. Back-to-back requests give a response every cycle.
- **Hit latency:** 1 cycle minimum from `hit_vld_i` to `plru_upd_en_hit_o`. Worst case with a continuous refill stream: stalls until the queue is full, then 1 drain cycle.
- **Invariant:** `plru_upd_en_hit_o & plru_rd_en_refill_o` is never 1.
- **Reset mid-refill:** the pending response is lost, with no pulse after reset.
- **Pointer wrap:** natural modulo `HIT_Q_DEPTH`. The count is `$clog2(HIT_Q_DEPTH)+1` bits wide.

## Structure
- Shared package `rvh_l1d_pkg` holds:
  - `SET_W` and `WAY_W` derivations
  - `plru_hit_req_t` struct `{set, way}` used for the queue entry
- Sub-module `rvh_l1d_plru_hit_q`: a multi-enqueue, single-dequeue FIFO that outputs `free` and the per-port accepted mask. The top level holds arbitration, the response register and the drop counter.
- The PLRU itself is instantiated by the parent, not inside this block.

## Test plan
- **Single hit:** `hit_vld_i = 2'b01` (set 5, way 2) in cycle 0, no refill → cycle 1: `plru_upd_en_hit_o = 1`, set 5, way 2; queue empty in cycle 2.
- **Refill priority and response:** queue holds 1 entry; refill request for set 9 with PLRU returning 3 → same cycle: `rd_en_refill = 1`, hit stalled. Next cycle: `refill_resp_vld_o = 1`, set 9, way 3, and the hit drains.
- **Overflow drop:** queue at count 3 with no drain, both ports valid → one entry accepted (port 0), port 1 dropped, `hit_drop_cnt_o = 1`. Check saturation at 255 after 300 drops.
- **Full-queue fairness:** continuous refill requests with the queue full → `refill_req_rdy_o = 0` for exactly 1 cycle while the head drains, then `rdy = 1` again.
- **Flush:** 3 queued entries plus port 0 valid and `flush_i` → count 0 next cycle, no further hit enables, drop count unchanged.
- **Async reset mid-refill:** assert `rstn = 0` in the cycle after a refill is accepted → `refill_resp_vld_o` goes to 0 immediately, no pulse after release, all outputs at reset values.
